// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
// Purpose : Bundles the CPU-side load/store request signals and the
//           memory-side handshake of the data memory controller.
// Signals : CPU side    - MemRead, MemWrite[3:0], Funct3[2:0], addr[31:0],
//                         wdata[31:0] (to controller); stall, rdata[31:0],
//                         err (from controller)
//           Memory side - mem_req, mem_we, mem_strb[3:0], mem_addr[31:0],
//                         mem_wdata[31:0] (from controller); mem_ready,
//                         mem_rdata[31:0] (to controller)
// Modports: slave  - the controller's view
//           master - the CPU + memory environment's view
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        MemRead;
    logic [3:0]  MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  MemRead, MemWrite, Funct3, addr, wdata, mem_ready, mem_rdata,
        output stall, rdata, err, mem_req, mem_we, mem_strb, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, Funct3, addr, wdata, mem_ready, mem_rdata,
        input  stall, rdata, err, mem_req, mem_we, mem_strb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Purpose : Data memory access controller for a CPU load/store unit. Checks
//           alignment and legality of a request, issues one lane-shifted
//           memory access, waits (bounded by TIMEOUT) for mem_ready and
//           returns the sign/zero-extended load result.
// Ports   : clk - clock (rising edge)
//           rst - synchronous active-high reset
//           bus - data_mem_ctrl_if.slave (CPU request/response and memory
//                 handshake signals)
// Params  : TIMEOUT - maximum number of WAIT cycles (1..255)
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_strb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;

    logic        w_req;
    logic [1:0]  w_size;      // 0 byte, 1 halfword, 2 word
    logic        w_aligned;
    logic        w_ok;
    logic        w_timeout;

    // Shift the memory word down to the addressed lane and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign w_req     = bus.MemRead | (bus.MemWrite != 4'b0000);
    assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));

    // Access size comes from Funct3 for loads and from the byte mask for stores.
    always_comb begin
        w_size = 2'd0;
        if (bus.MemRead) begin
            w_size = bus.Funct3[1:0];
        end else begin
            case (bus.MemWrite)
                4'b0011: w_size = 2'd1;
                4'b1111: w_size = 2'd2;
                default: w_size = 2'd0;
            endcase
        end
    end

    always_comb begin
        w_aligned = 1'b1;
        if (w_size == 2'd2)      w_aligned = (bus.addr[1:0] == 2'b00);
        else if (w_size == 2'd1) w_aligned = ~bus.addr[0];
    end

    // A load must not carry a store mask; Funct3 3'b011/110/111 are not loads.
    always_comb begin
        w_ok = 1'b0;
        if (bus.MemRead)
            w_ok = (bus.MemWrite == 4'b0000) &&
                   (bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            w_ok = bus.MemWrite inside {4'b0001, 4'b0011, 4'b1111};
        w_ok = w_ok & w_aligned;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = w_ok ? WAIT : FAULT;
            WAIT:    begin
                if (bus.mem_ready)  w_next = DONE;
                else if (w_timeout) w_next = FAULT;
            end
            DONE:    w_next = IDLE;
            FAULT:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_strb  <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_off       <= 2'd0;
            r_funct3    <= 3'd0;
        end else begin
            r_state <= w_next;
            r_err   <= (w_next == FAULT);
            r_rdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= 8'd0;
                    if (w_req && w_ok) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ~bus.MemRead;
                        r_mem_strb  <= bus.MemWrite << bus.addr[1:0];
                        r_mem_addr  <= {bus.addr[31:2], 2'b00};
                        r_mem_wdata <= bus.wdata << {bus.addr[1:0], 3'b000};
                        r_off       <= bus.addr[1:0];
                        r_funct3    <= bus.Funct3;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_mem_we ? 32'd0
                                              : load_extract(bus.mem_rdata, r_off, r_funct3);
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: r_wait_cnt <= 8'd0;
            endcase
        end
    end

    // stall is combinational so the CPU is held in the very cycle it requests.
    assign bus.stall     = ~rst & (((r_state == IDLE) & w_req) | (r_state == WAIT));
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_strb  = r_mem_strb;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 4'b0000;
        bus.Funct3   = 3'b000;
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
    endtask

    // Reference rules: legality, access size in bytes, lane placement.
    function automatic bit ref_legal(input bit rd, input logic [3:0] m,
                                     input logic [2:0] f3, input logic [31:0] a);
        int sz;
        bit ok;
        if (rd) begin
            ok = (m == 0) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        end else begin
            ok = (m == 1 || m == 3 || m == 15);
            sz = (m == 3) ? 2 : (m == 15) ? 4 : 1;
        end
        return ok && (a % sz == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input int off);
        longint sh, v;
        sh = longint'(w) / (longint'(1) << (8 * off));
        case (f3)
            3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = sh % 256;
            3'd5: v = sh % 65536;
            default: v = sh;
        endcase
        return 32'(v);
    endfunction

    // One complete access. rdy = WAIT cycle in which mem_ready rises (0 = never).
    task automatic access(input string tag, input bit rd, input logic [3:0] m,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int rdy, input logic [31:0] word);
        bit   legal, tmo;
        int   nwait, off;
        logic [31:0] exp_rd;
        legal = ref_legal(rd, m, f3, a);
        off   = a % 4;
        tmo   = (rdy == 0) || (rdy > TO);
        nwait = tmo ? TO : rdy;
        @(negedge clk);
        bus.MemRead = rd; bus.MemWrite = m; bus.Funct3 = f3; bus.addr = a; bus.wdata = wd;
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, ".req_stall"}, 32'(bus.stall), 32'd1);
        chk({tag, ".req_memreq"}, 32'(bus.mem_req), 32'd0);
        chk({tag, ".req_err"}, 32'(bus.err), 32'd0);
        if (legal) begin
            for (int k = 1; k <= nwait; k++) begin
                @(negedge clk);
                bus.MemRead = $urandom; bus.MemWrite = $urandom; bus.Funct3 = $urandom;
                bus.addr = $urandom; bus.wdata = $urandom;
                bus.mem_ready = (k == rdy);
                bus.mem_rdata = (k == rdy) ? word : $urandom;
                #1;
                chk({tag, ".w_stall"}, 32'(bus.stall), 32'd1);
                chk({tag, ".w_memreq"}, 32'(bus.mem_req), 32'd1);
                chk({tag, ".w_we"}, 32'(bus.mem_we), 32'(!rd));
                chk({tag, ".w_addr"}, bus.mem_addr, a - 32'(off));
                if (!rd) begin
                    chk({tag, ".w_strb"}, 32'(bus.mem_strb), 32'(int'(m) * (1 << off)));
                    chk({tag, ".w_wdata"}, bus.mem_wdata,
                        32'(longint'(wd) * (longint'(1) << (8 * off))));
                end
            end
        end
        exp_rd = (legal && !tmo && rd) ? ref_load(word, f3, off) : 32'd0;
        @(negedge clk);
        drive_idle();
        bus.mem_ready = $urandom;
        bus.mem_rdata = $urandom;
        #1;
        chk({tag, ".end_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".end_memreq"}, 32'(bus.mem_req), 32'd0);
        chk({tag, ".end_err"}, 32'(bus.err), 32'(!legal || tmo));
        chk({tag, ".end_rdata"}, bus.rdata, exp_rd);
    endtask

    initial begin
        bit   rd;
        logic [3:0] m;
        logic [2:0] f3;
        logic [3:0] masks [6];
        masks = '{4'b0001, 4'b0011, 4'b1111, 4'b0010, 4'b0110, 4'b0000};

        drive_idle();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;

        // Reset: outputs cleared, stall low even with a request present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.MemRead = 1'b1;
        #1;
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.memreq", 32'(bus.mem_req), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.strb", 32'(bus.mem_strb), 32'd0);
        chk("rst.addr", bus.mem_addr, 32'd0);
        chk("rst.wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("idle_ready.memreq", 32'(bus.mem_req), 32'd0);
        chk("idle_ready.stall", 32'(bus.stall), 32'd0);
        chk("idle_ready.rdata", bus.rdata, 32'd0);

        // Directed vectors.
        access("sw104", 0, 4'b1111, 3'd0, 32'h104, 32'hDEADBEEF, 2, 32'h0);
        access("sb203", 0, 4'b0001, 3'd0, 32'h203, 32'h000000A5, 1, 32'h0);
        access("lb302", 1, 4'b0000, 3'd0, 32'h302, 32'h0, 1, 32'h12F03456);
        access("lbu302", 1, 4'b0000, 3'd4, 32'h302, 32'h0, 3, 32'h12F03456);
        access("lhu302", 1, 4'b0000, 3'd5, 32'h302, 32'h0, 1, 32'h12F03456);
        access("lh302", 1, 4'b0000, 3'd1, 32'h302, 32'h0, 1, 32'h12F03456);
        access("lw101", 1, 4'b0000, 3'd2, 32'h101, 32'h0, 1, 32'h0);
        access("lwtmo", 1, 4'b0000, 3'd2, 32'h100, 32'h0, 0, 32'h0);
        access("lw_last", 1, 4'b0000, 3'd2, 32'h180, 32'h0, TO, 32'hCAFEF00D);
        access("sh_mis", 0, 4'b0011, 3'd0, 32'h201, 32'h1234, 1, 32'h0);
        access("rd_wr", 1, 4'b0001, 3'd0, 32'h200, 32'h0, 1, 32'h0);
        access("bad_f3", 1, 4'b0000, 3'd3, 32'h200, 32'h0, 1, 32'h0);

        // Reset in the third WAIT cycle discards the access without err.
        @(negedge clk);
        bus.MemRead = 1'b1; bus.Funct3 = 3'd2; bus.addr = 32'h400;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            drive_idle();
            bus.mem_ready = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw.stall_in_rst", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw.memreq", 32'(bus.mem_req), 32'd0);
        chk("rstw.stall", 32'(bus.stall), 32'd0);
        chk("rstw.err", 32'(bus.err), 32'd0);
        access("lw_after_rst", 1, 4'b0000, 3'd2, 32'h404, 32'h0, 1, 32'h89ABCDEF);

        // Randomized accesses against the reference rules.
        for (int i = 0; i < 60; i++) begin
            rd = $urandom_range(0, 1);
            m  = rd ? (($urandom_range(0, 7) == 0) ? 4'b0001 : 4'b0000)
                    : masks[$urandom_range(0, 4)];
            f3 = $urandom_range(0, 7);
            if (!rd && m == 4'b0000) m = 4'b0001;
            access("rand", rd, m, f3, $urandom, $urandom, $urandom_range(0, 17), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
